id_fetch_arbiter: RTL and testbench



---
 rtl/ariane_pkg.sv | 29 ++
 rtl/id_fetch_arbiter_rr_picker.sv | 33 +++
 rtl/id_fetch_arbiter.sv | 144 ++++++++++++++
 tb/tb_id_fetch_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ariane_pkg.sv
// Core-wide types shared by the ID stage and its fetch arbiter.
// fetch_entry_t mirrors the frontend's fetch queue entry layout.
package ariane_pkg;

   typedef struct packed {
      logic [63:0] address;
      logic [31:0] instruction;
      logic        is_compressed;
   } fetch_entry_t;

   // Upper bound on fetch sources the ID arbiter is sized for.
   localparam int unsigned IdArbMaxReq = 16;
   localparam int unsigned IdArbIdxW   = $clog2(IdArbMaxReq);
   localparam int unsigned IdArbCntW   = 8;

   typedef struct packed {
      logic                 lock;
      logic [IdArbIdxW-1:0] owner;
      logic [IdArbCntW-1:0] burst_cnt;
      logic [IdArbIdxW-1:0] rr_ptr;
   } id_arb_state_t;

   // Increment with explicit wrap so non-power-of-2 source counts stay in range.
   function automatic int unsigned id_arb_wrap_inc(input int unsigned idx,
                                                   input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/id_fetch_arbiter_rr_picker.sv
// Rotate-priority picker: first set bit of valid_i at or after ptr_i, wrapping.
// Purely combinational; found_o is low when no bit is set.
module id_rr_picker #(
   parameter int unsigned NrReq = 2
) (
   input  logic [NrReq-1:0]         valid_i,
   input  logic [$clog2(NrReq)-1:0] ptr_i,
   output logic [$clog2(NrReq)-1:0] idx_o,
   output logic                     found_o
);

   localparam int unsigned IdxW = $clog2(NrReq);

   int unsigned      j;
   logic [IdxW-1:0]  jj;

   always_comb begin
      idx_o   = '0;
      found_o = 1'b0;
      j       = '0;
      jj      = '0;
      for (int k = 0; k < NrReq; k++) begin
         j = 32'(ptr_i) + unsigned'(k);
         if (j >= NrReq) j = j - NrReq;
         jj = IdxW'(j);
         if (!found_o && valid_i[jj]) begin
            idx_o   = jj;
            found_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/id_fetch_arbiter.sv
// Shares the ID-stage fetch input between NrReq sources: round-robin with
// grant lock on backpressure and bounded bursts; zero-latency data path.
module id_fetch_arbiter
   import ariane_pkg::*;
#(
   parameter int unsigned NrReq    = 2,
   parameter int unsigned BurstLen = 4
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         clr_i,
   input  logic                         flush_i,
   input  fetch_entry_t [NrReq-1:0]     req_entry_i,
   input  logic [NrReq-1:0]             req_valid_i,
   output logic [NrReq-1:0]             req_ready_o,
   output fetch_entry_t                 fetch_entry_o,
   output logic                         fetch_entry_valid_o,
   input  logic                         fetch_entry_ready_i,
   output logic [$clog2(NrReq)-1:0]     gnt_idx_o
);

   localparam int unsigned IdxW = $clog2(NrReq);
   localparam int unsigned CntW = $clog2(BurstLen + 1);

   logic            lock_q, lock_d;
   logic [IdxW-1:0] owner_q, owner_d;
   logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
   logic [CntW-1:0] burst_cnt_q, burst_cnt_d;
   logic [CntW-1:0] burst_base;

   logic [IdxW-1:0] pick_ptr, pick_idx, gnt;
   logic            pick_found, owner_valid, burst_abort, hs;

   function automatic logic [IdxW-1:0] wrap_inc(input logic [IdxW-1:0] idx);
      return IdxW'(id_arb_wrap_inc(32'(idx), NrReq));
   endfunction

   // An unlocked burst whose owner went idle is abandoned; rotation restarts past it.
   assign owner_valid = req_valid_i[owner_q];
   assign burst_abort = (burst_cnt_q != '0) && !lock_q && !owner_valid;
   assign pick_ptr    = burst_abort ? wrap_inc(owner_q) : rr_ptr_q;

   id_rr_picker #(
      .NrReq (NrReq)
   ) i_picker (
      .valid_i (req_valid_i),
      .ptr_i   (pick_ptr),
      .idx_o   (pick_idx),
      .found_o (pick_found)
   );

   always_comb begin
      gnt = owner_q;
      if (lock_q)                                      gnt = owner_q;
      else if ((burst_cnt_q != '0) && owner_valid)     gnt = owner_q;
      else if (pick_found)                             gnt = pick_idx;
   end

   // Reset gates the outputs immediately so a locked source is never acked.
   assign fetch_entry_o       = req_entry_i[gnt];
   assign fetch_entry_valid_o = req_valid_i[gnt] & ~flush_i & ~rst_i;
   assign hs                  = fetch_entry_valid_o & fetch_entry_ready_i;
   assign gnt_idx_o           = rst_i ? '0 : gnt;

   always_comb begin
      req_ready_o      = '0;
      req_ready_o[gnt] = hs;
   end

   always_comb begin
      lock_d      = lock_q;
      owner_d     = owner_q;
      burst_cnt_d = burst_cnt_q;
      rr_ptr_d    = rr_ptr_q;
      burst_base  = burst_abort ? '0 : burst_cnt_q;
      if (flush_i) begin
         lock_d      = 1'b0;
         burst_cnt_d = '0;
      end else begin
         if (burst_abort) begin
            burst_cnt_d = '0;
            rr_ptr_d    = wrap_inc(owner_q);
         end
         if (hs) begin
            lock_d = 1'b0;
            if (32'(burst_base) + 1 < BurstLen) begin
               burst_cnt_d = burst_base + 1'b1;
               owner_d     = gnt;
            end else begin
               burst_cnt_d = '0;
               rr_ptr_d    = wrap_inc(gnt);
            end
         end else if (fetch_entry_valid_o) begin
            lock_d  = 1'b1;
            owner_d = gnt;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         lock_q      <= 1'b0;
         owner_q     <= '0;
         burst_cnt_q <= '0;
         rr_ptr_q    <= '0;
      end else if (clr_i) begin
         lock_q      <= 1'b0;
         owner_q     <= '0;
         burst_cnt_q <= '0;
         rr_ptr_q    <= '0;
      end else begin
         lock_q      <= lock_d;
         owner_q     <= owner_d;
         burst_cnt_q <= burst_cnt_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

`ifndef SYNTHESIS
   logic            chk_pend_q;
   logic [IdxW-1:0] chk_idx_q;
   fetch_entry_t    chk_entry_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         chk_pend_q <= 1'b0;
      end else begin
         chk_pend_q <= fetch_entry_valid_o & ~fetch_entry_ready_i & ~clr_i;
      end
   end

   always_ff @(posedge clk_i) begin
      chk_idx_q   <= gnt;
      chk_entry_q <= fetch_entry_o;
   end

   // A presented but unaccepted source must keep valid and entry stable.
   always @(posedge clk_i) begin
      if (!rst_i && chk_pend_q && !flush_i)
         assert (req_valid_i[chk_idx_q] && (req_entry_i[chk_idx_q] == chk_entry_q));
   end
`endif

endmodule

// File: tb/tb_id_fetch_arbiter.sv
// Bench for id_fetch_arbiter (NrReq=3, BurstLen=4): directed scenarios plus
// randomized traffic compared against a behavioural model of the arbitration rules.
module tb_id_fetch_arbiter;
   import ariane_pkg::*;

   localparam int N = 3;
   localparam int B = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 rst, clr, flush, rdy;
   logic [N-1:0]         vld;
   fetch_entry_t [N-1:0] ent;
   logic [N-1:0]         ready_o;
   fetch_entry_t         ent_o;
   logic                 valid_o;
   logic [1:0]           gnt_o;

   int total = 0;
   int bad   = 0;

   bit m_lock;
   int m_owner, m_cnt, m_rr;

   id_fetch_arbiter #(
      .NrReq    (N),
      .BurstLen (B)
   ) dut (
      .clk_i               (clk),
      .rst_i               (rst),
      .clr_i               (clr),
      .flush_i             (flush),
      .req_entry_i         (ent),
      .req_valid_i         (vld),
      .req_ready_o         (ready_o),
      .fetch_entry_o       (ent_o),
      .fetch_entry_valid_o (valid_o),
      .fetch_entry_ready_i (rdy),
      .gnt_idx_o           (gnt_o)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic fetch_entry_t rand_entry();
      fetch_entry_t e;
      e.address       = {$urandom, $urandom};
      e.instruction   = $urandom;
      e.is_compressed = 1'($urandom_range(0, 1));
      return e;
   endfunction

   function automatic void model_reset();
      m_lock  = 1'b0;
      m_owner = 0;
      m_cnt   = 0;
      m_rr    = 0;
   endfunction

   function automatic bit model_abort();
      return (m_cnt > 0) && !m_lock && !vld[m_owner[1:0]];
   endfunction

   // Grant: locked/continuing owner, else first valid source scanning from the pointer.
   function automatic void model_out(output int g, output bit v);
      int ptr;
      ptr = model_abort() ? (m_owner + 1) % N : m_rr;
      g = m_owner;
      if (!(m_lock || (m_cnt > 0 && vld[m_owner[1:0]]))) begin
         for (int k = N - 1; k >= 0; k--) begin
            int j;
            j = (ptr + k) % N;
            if (vld[j[1:0]]) g = j;
         end
      end
      v = vld[g[1:0]] && !flush && !rst;
   endfunction

   function automatic void model_seq(input int g, input bit v);
      if (rst || clr) begin
         model_reset();
      end else if (flush) begin
         m_lock = 1'b0;
         m_cnt  = 0;
      end else begin
         if (model_abort()) begin
            m_cnt = 0;
            m_rr  = (m_owner + 1) % N;
         end
         if (v && rdy) begin
            m_lock = 1'b0;
            if (m_cnt + 1 < B) begin
               m_cnt   = m_cnt + 1;
               m_owner = g;
            end else begin
               m_cnt = 0;
               m_rr  = (g + 1) % N;
            end
         end else if (v) begin
            m_lock  = 1'b1;
            m_owner = g;
         end
      end
   endfunction

   // Called at posedge+1 with inputs already set; checks mid-cycle, then advances.
   task automatic step(input string tag, input int exp_g);
      int           g;
      bit           v;
      logic [N-1:0] er;
      #3;
      model_out(g, v);
      er = (v && rdy) ? 3'(1 << g) : 3'b000;
      check({tag, ".valid"}, 128'(valid_o), 128'(v));
      check({tag, ".ready"}, 128'(ready_o), 128'(er));
      check({tag, ".gnt"}, 128'(gnt_o), rst ? 128'(0) : 128'(g));
      if (!rst) check({tag, ".entry"}, 128'(ent_o), 128'(ent[g[1:0]]));
      if (exp_g >= 0) check({tag, ".dir"}, 128'(gnt_o), 128'(exp_g));
      @(posedge clk);
      model_seq(g, v);
      #1;
   endtask

   task automatic clear_step();
      clr = 1'b1;
      step("clr", -1);
      clr = 1'b0;
   endtask

   initial begin
      int burst_exp [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
      model_reset();
      rst   = 1'b1;
      clr   = 1'b0;
      flush = 1'b0;
      rdy   = 1'b1;
      vld   = 3'b111;
      for (int i = 0; i < N; i++) ent[i] = rand_entry();

      // Reset with every source valid
      @(posedge clk);
      #1;
      check("rst.valid", 128'(valid_o), 128'(0));
      check("rst.ready", 128'(ready_o), 128'(0));
      check("rst.gnt", 128'(gnt_o), 128'(0));
      step("rst", 0);
      rst = 1'b0;

      // Bursts of four alternating between sources 0 and 1
      vld = 3'b011;
      for (int k = 0; k < 9; k++) step("burst", burst_exp[k]);

      // Lock under backpressure, then release
      clear_step();
      vld = 3'b011;
      rdy = 1'b0;
      for (int k = 0; k < 3; k++) step("lock.hold", 0);
      rdy = 1'b1;
      step("lock.ack", 0);
      vld = 3'b010;
      step("lock.clr", 1);

      // Burst abort and rotation
      clear_step();
      vld = 3'b011;
      step("abort.b0", 0);
      step("abort.b1", 0);
      vld = 3'b010;
      step("abort.sw", 1);
      vld = 3'b011;
      step("abort.r1", 1);
      step("abort.r2", 1);
      step("abort.r3", 1);
      step("abort.rot", 0);

      // Flush while locked on source 1
      clear_step();
      vld = 3'b010;
      rdy = 1'b0;
      step("flush.lk", 1);
      flush = 1'b1;
      rdy   = 1'b1;
      step("flush.cyc", 1);
      flush = 1'b0;
      vld   = 3'b011;
      step("flush.after", 0);

      // Only source 2 valid: rr pointer wraps 2 -> 0
      clear_step();
      vld = 3'b100;
      for (int k = 0; k < 4; k++) step("wrap.b", 2);
      vld = 3'b111;
      step("wrap.rot", 0);

      // Asynchronous reset while locked on source 1
      clear_step();
      vld = 3'b010;
      rdy = 1'b0;
      step("arst.lk", 1);
      #1;
      rst = 1'b1;
      #1;
      model_reset();
      check("arst.valid", 128'(valid_o), 128'(0));
      check("arst.ready", 128'(ready_o), 128'(0));
      check("arst.gnt", 128'(gnt_o), 128'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      vld = 3'b011;
      rdy = 1'b1;
      step("arst.after", 0);

      // Random traffic; a locked source holds its valid and entry
      clear_step();
      for (int n = 0; n < 1500; n++) begin
         for (int i = 0; i < N; i++) begin
            if (!(m_lock && m_owner == i)) begin
               vld[i[1:0]] = ($urandom_range(0, 9) < 6);
               ent[i[1:0]] = rand_entry();
            end
         end
         rdy   = ($urandom_range(0, 9) < 7);
         flush = ($urandom_range(0, 19) == 0);
         clr   = ($urandom_range(0, 49) == 0);
         step("rnd", -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
